cp0_timer_ctrl: RTL
===================

# cp0_timer_ctrl

CP0 timer controller for the MIPS core: owns the Count and Compare registers, sequences the Count increment, and raises the timer interrupt (Cause.TI / IP7). Sits beside the other CP0 registers in the CP0 block, takes the committed MTC0 write port and drives read data, plus an interrupt line into the Cause/interrupt logic.

## Interface
- No parameters.
- clk  input  1  core clock
- rst_n  input  1  reset; synchronous, active-low
- mtc0_we  input  1  MTC0 write strobe from writeback
- exception  input  1  exception/flush in the writeback stage; blocks the write this cycle
- cp0_addr  input  8  CP0 address {rd[4:0], sel[2:0]}; Count = 8'h48, Compare = 8'h58
- mtc0_data  input  32  MTC0 write data
- count_data  output  32  Count register
- compare_data  output  32  Compare register
- timer_int  output  1  level TI; feeds Cause.IP7
- ti_pulse  output  1  one-cycle strobe on TI 0->1

## Operation
- Commit: wr_ok = mtc0_we & ~exception. wr_count = wr_ok & (cp0_addr == 8'h48); wr_cmp = wr_ok & (cp0_addr == 8'h58). Other addresses ignored.
- Tick phase: 1-bit register tick, toggles every cycle; Count increments on cycles with tick == 1 (Count advances every 2nd clock).
- Count update priority, per cycle: wr_count -> Count <= mtc0_data, tick <= 0; else if increment -> Count <= Count + 1, modulo 2^32 (32'hFFFF_FFFF wraps to 0, no flag).
- Compare: wr_cmp -> Compare <= mtc0_data. No other updates.
- Match: hit = (count_data == compare_data), on registered values.
- TI update priority: wr_cmp -> TI <= 0; else if hit -> TI <= 1; else hold. Only a Compare write clears TI; Count writes do not.
- ti_pulse = TI_next & ~TI registered (high the cycle TI first reads 1).
- Simultaneous wr_count and hit: TI still sets (hit uses old Count).
- Simultaneous wr_cmp and hit: clear wins; if the new Compare still equals Count, TI sets one cycle later.
- exception with mtc0_we: no register changes; Count keeps incrementing.

## Timing
- Reset values: count_data 0, compare_data 32'hFFFF_FFFF, timer_int 0, ti_pulse 0, tick 0.
- First increment: Count = 1 on the 2nd edge after rst_n deasserts (DIV2 build).
- MTC0 write at edge N is visible on count_data/compare_data after edge N.
- Match latency: Count reaches Compare after edge N -> timer_int = 1 and ti_pulse = 1 after edge N+1; ti_pulse low after N+2.
- After wr_count, next increment occurs 2 edges later (tick restarts at 0).
- Reset mid-operation: all state returns to reset values on the next edge; pending TI discarded.

## Configuration
- CP0_TIMER_DIV2_EN defined: tick divider present; Count increments every 2nd clock as above.
- Not defined: tick removed; Count increments every clock (Count = 1 after 1st edge post-reset); wr_count still has priority over increment.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles -> count_data 0, compare_data 32'hFFFF_FFFF, timer_int 0; release -> Count 1, 2, 3 after edges 2, 4, 6.
- Match: MTC0 Compare = 10 -> Count reaches 10; timer_int = 1 and ti_pulse = 1 for exactly one cycle on the following edge; timer_int stays 1 while Count moves to 11, 12.
- Clear: with timer_int = 1, MTC0 Compare = 100 -> timer_int 0 next cycle; stays 0 until Count = 100; rewriting Compare = current Count -> TI clears, then re-sets one cycle later.
- Count write: MTC0 Count = 32'hFFFF_FFFE -> Count reads FFFF_FFFE, FFFF_FFFF, 0 after edges +1, +3, +5; timer_int unaffected by the write.
- Flush: mtc0_we = 1, exception = 1, cp0_addr = 8'h58, data 5 -> compare_data unchanged; same with address 8'h48 -> Count keeps incrementing.
- Config off: build without CP0_TIMER_DIV2_EN -> Count increments every edge; Compare = 4 -> timer_int = 1 after edge 5 post-reset.

Source files
------------

// File: rtl/cp0_timer_ctrl.sv
// CP0 Count/Compare timer: Count increment sequencing, Compare match, and timer interrupt (TI/IP7).
// Optional macro CP0_TIMER_DIV2_EN adds a tick divider so Count advances every 2nd clock.
module cp0_timer_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mtc0_we,
  input  logic        exception,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] mtc0_data,
  output logic [31:0] count_data,
  output logic [31:0] compare_data,
  output logic        timer_int,
  output logic        ti_pulse
);

  localparam logic [7:0]  ADDR_COUNT    = 8'h48;
  localparam logic [7:0]  ADDR_COMPARE  = 8'h58;
  localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

  logic        wr_ok;
  logic        wr_count;
  logic        wr_cmp;
  logic        inc;
  logic        hit;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        pulse_q, pulse_d;

  // A flushed MTC0 never commits.
  assign wr_ok    = mtc0_we & ~exception;
  assign wr_count = wr_ok & (cp0_addr == ADDR_COUNT);
  assign wr_cmp   = wr_ok & (cp0_addr == ADDR_COMPARE);

`ifdef CP0_TIMER_DIV2_EN
  logic tick_q, tick_d;

  // A Count write restarts the phase so the next increment lands two edges later.
  always_comb begin
    tick_d = ~tick_q;
    if (wr_count) begin
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign inc = tick_q;
`else
  assign inc = 1'b1;
`endif

  assign hit = (count_q == compare_q);

  always_comb begin
    count_d = count_q;
    if (wr_count) begin
      count_d = mtc0_data;
    end else if (inc) begin
      count_d = count_q + 32'd1;
    end
  end

  always_comb begin
    compare_d = compare_q;
    if (wr_cmp) begin
      compare_d = mtc0_data;
    end
  end

  // Compare write clears TI even when the old values match; a still-matching
  // new Compare re-raises it on the following edge.
  always_comb begin
    ti_d = ti_q;
    if (wr_cmp) begin
      ti_d = 1'b0;
    end else if (hit) begin
      ti_d = 1'b1;
    end
  end

  assign pulse_d = ti_d & ~ti_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= COMPARE_RESET;
      ti_q      <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      pulse_q   <= pulse_d;
    end
  end

  assign count_data   = count_q;
  assign compare_data = compare_q;
  assign timer_int    = ti_q;
  assign ti_pulse     = pulse_q;

endmodule
